ram_access_arbiter: RTL and testbench
=====================================

Name: ram_access_arbiter

Overview:
- Sequences all accesses to the byte-addressed, big-endian, combinational RAM (64-bit word at address..address+7, write whenever isReading=0).
- Shares the single RAM port between the instruction-fetch requester and the load/store requester.
- Guarantees that isReading drops only for one cycle, with address and data already stable, so no spurious or partial writes occur.
- Sits between the CPU pipeline and the RAM.

Parameters:
ADDRESS_SIZE, 11, RAM address width (matches RAM)
MEM_WORD_SIZE, 64, RAM data word width in bits
INSTR_SIZE, 32, fetch word width; taken from the upper bits of the RAM word

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
fetch_req  input  1  fetch request; held high with fetch_addr stable until fetch_done
fetch_addr  input  ADDRESS_SIZE  instruction byte address; must be 4-aligned
fetch_done  output  1  one-cycle pulse: fetch finished
fetch_instr  output  INSTR_SIZE  bytes addr..addr+3, big-endian; valid while fetch_done=1
fetch_err  output  1  with fetch_done: misaligned, no RAM access made
data_req  input  1  load/store request; held with all data_* inputs stable until data_done
data_write  input  1  1=store, 0=load
data_addr  input  ADDRESS_SIZE  byte address; must be 8-aligned
data_wdata  input  MEM_WORD_SIZE  store data, big-endian
data_done  output  1  one-cycle pulse: load/store finished
data_rdata  output  MEM_WORD_SIZE  load data; valid while data_done=1
data_err  output  1  with data_done: misaligned, no RAM access made
ram_address  output  ADDRESS_SIZE  to RAM address
ram_isReading  output  1  to RAM isReading; 0 means write
ram_dataIn  output  MEM_WORD_SIZE  to RAM dataIn
ram_dataOut  input  MEM_WORD_SIZE  from RAM dataOut
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, immediate):
  - State = IDLE; ram_isReading=1; ram_address=0; ram_dataIn=0.
  - All done/err pulses 0; fetch_instr=0; data_rdata=0; last_grant=DATA.
- ram_isReading is a registered output. It is 0 only in WR_PULSE; every other state, including reset, drives 1.
- States: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, RESP.
- IDLE arbitration, evaluated each cycle:
  - Only one requester asserting: that requester wins.
  - Both asserting: round-robin; the requester that was not last_grant wins. After reset, fetch wins the first tie.
  - last_grant updates to the winner on every grant.
- Alignment check at grant:
  - Fetch is misaligned if fetch_addr[1:0]!=0; data is misaligned if data_addr[2:0]!=0.
  - On misalignment: go directly to RESP, assert err with done, make no RAM access, and leave ram_address unchanged.
- Read (fetch, or data with data_write=0):
  - IDLE→READ; ram_address is registered to the request address.
  - READ lasts one cycle; at its end, capture ram_dataOut.
  - Fetch: fetch_instr = ram_dataOut[63:32]. Load: data_rdata = ram_dataOut.
  - READ→RESP.
  - Latency: grant cycle N, done pulse in cycle N+2.
- Write (data_write=1):
  - IDLE→WR_SETUP: register ram_address and ram_dataIn; isReading stays 1.
  - WR_SETUP→WR_PULSE: isReading=0 for exactly one cycle.
  - WR_PULSE→WR_HOLD: isReading=1; address and data held.
  - WR_HOLD→RESP. Done pulse in cycle N+4.
- RESP:
  - Asserts the winner's done (plus err if misaligned) for one cycle, then returns to IDLE.
  - Requester deasserts req in the cycle after done. Re-arbitration occurs in IDLE the following cycle, so a req still high then is treated as a new request.
- Back-to-back:
  - Minimum 3-cycle period for reads and 5 for writes, including the IDLE cycle.
  - Captured output data holds its value until the next capture for that port; it is defined only while done=1.
- A request dropped mid-operation is ignored: the operation completes and done still pulses.
- Reset mid-write forces ram_isReading=1 asynchronously. The write either completes in full or not at all; no partial-byte update can arise from the controller.
- ram_address is never changed while ram_isReading=0.

Test Plan:
- Load: RAM preloaded with bytes 0x00..0x07 at address 0; data_req, data_write=0, addr=0 → data_done 2 cycles after grant, data_rdata=0x0001020304050607, data_err=0.
- Store then load: store 0xDEADBEEFCAFEF00D at 0x010 → ram_isReading low exactly 1 cycle with ram_address=0x010; RAM bytes 0x10..0x17 = DE AD BE EF CA FE F0 0D; load of 0x010 returns the same value; no other byte changes.
- Fetch: bytes 0x18..0x1B = 8B 02 00 01 → fetch_instr=0x8B020001 with fetch_done 2 cycles after grant.
- Contention: fetch_req and data_req both held high from reset → grants go fetch, data, fetch, data; each done pulses once per transaction; the two ports never complete in the same cycle.
- Misaligned: data_addr=0x00C → data_done with data_err=1 one cycle after grant, ram_isReading stays 1, memory unchanged. fetch_addr=0x002 → fetch_err=1.
- Reset during WR_PULSE → ram_isReading=1 immediately; state IDLE, busy=0, no done pulse; the next request is serviced normally.

Source files
------------

// File: rtl/ram_access_arbiter.sv
// Arbitrates the single combinational RAM port between instruction fetch and load/store.
// Writes use a setup/pulse/hold sequence so isReading is low for exactly one cycle.
module ram_access_arbiter #(
    parameter int ADDRESS_SIZE  = 11,
    parameter int MEM_WORD_SIZE = 64,
    parameter int INSTR_SIZE    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_req,
    input  logic [ADDRESS_SIZE-1:0]  fetch_addr,
    output logic                     fetch_done,
    output logic [INSTR_SIZE-1:0]    fetch_instr,
    output logic                     fetch_err,
    input  logic                     data_req,
    input  logic                     data_write,
    input  logic [ADDRESS_SIZE-1:0]  data_addr,
    input  logic [MEM_WORD_SIZE-1:0] data_wdata,
    output logic                     data_done,
    output logic [MEM_WORD_SIZE-1:0] data_rdata,
    output logic                     data_err,
    output logic [ADDRESS_SIZE-1:0]  ram_address,
    output logic                     ram_isReading,
    output logic [MEM_WORD_SIZE-1:0] ram_dataIn,
    input  logic [MEM_WORD_SIZE-1:0] ram_dataOut,
    output logic                     busy
);

    typedef enum logic [2:0] {IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, RESP} state_t;

    state_t                   state_q, state_d;
    logic                     owner_data_q, owner_data_d;
    logic                     last_grant_q, last_grant_d;
    logic                     fetch_done_q, fetch_done_d;
    logic                     fetch_err_q, fetch_err_d;
    logic                     data_done_q, data_done_d;
    logic                     data_err_q, data_err_d;
    logic [INSTR_SIZE-1:0]    fetch_instr_q, fetch_instr_d;
    logic [MEM_WORD_SIZE-1:0] data_rdata_q, data_rdata_d;
    logic [ADDRESS_SIZE-1:0]  ram_address_q, ram_address_d;
    logic                     ram_is_reading_q, ram_is_reading_d;
    logic [MEM_WORD_SIZE-1:0] ram_data_in_q, ram_data_in_d;
    logic                     pick_data;

    always_comb begin
        state_d       = state_q;
        owner_data_d  = owner_data_q;
        last_grant_d  = last_grant_q;
        fetch_done_d  = 1'b0;
        fetch_err_d   = 1'b0;
        data_done_d   = 1'b0;
        data_err_d    = 1'b0;
        fetch_instr_d = fetch_instr_q;
        data_rdata_d  = data_rdata_q;
        ram_address_d = ram_address_q;
        ram_data_in_d = ram_data_in_q;
        // On a tie, the side that did not win last time goes next
        pick_data     = data_req && (!fetch_req || !last_grant_q);

        case (state_q)
            IDLE: begin
                if (fetch_req || data_req) begin
                    owner_data_d = pick_data;
                    last_grant_d = pick_data;
                    if (pick_data) begin
                        if (data_addr[2:0] != 3'b000) begin
                            state_d     = RESP;
                            data_done_d = 1'b1;
                            data_err_d  = 1'b1;
                        end else if (data_write) begin
                            state_d       = WR_SETUP;
                            ram_address_d = data_addr;
                            ram_data_in_d = data_wdata;
                        end else begin
                            state_d       = READ;
                            ram_address_d = data_addr;
                        end
                    end else begin
                        if (fetch_addr[1:0] != 2'b00) begin
                            state_d      = RESP;
                            fetch_done_d = 1'b1;
                            fetch_err_d  = 1'b1;
                        end else begin
                            state_d       = READ;
                            ram_address_d = fetch_addr;
                        end
                    end
                end
            end
            READ: begin
                state_d = RESP;
                if (owner_data_q) begin
                    data_rdata_d = ram_dataOut;
                    data_done_d  = 1'b1;
                end else begin
                    fetch_instr_d = ram_dataOut[MEM_WORD_SIZE-1 -: INSTR_SIZE];
                    fetch_done_d  = 1'b1;
                end
            end
            WR_SETUP: state_d = WR_PULSE;
            WR_PULSE: state_d = WR_HOLD;
            WR_HOLD: begin
                state_d     = RESP;
                data_done_d = 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ram_is_reading_d = (state_d != WR_PULSE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            owner_data_q     <= 1'b0;
            last_grant_q     <= 1'b1;
            fetch_done_q     <= 1'b0;
            fetch_err_q      <= 1'b0;
            data_done_q      <= 1'b0;
            data_err_q       <= 1'b0;
            fetch_instr_q    <= '0;
            data_rdata_q     <= '0;
            ram_address_q    <= '0;
            ram_is_reading_q <= 1'b1;
            ram_data_in_q    <= '0;
        end else begin
            state_q          <= state_d;
            owner_data_q     <= owner_data_d;
            last_grant_q     <= last_grant_d;
            fetch_done_q     <= fetch_done_d;
            fetch_err_q      <= fetch_err_d;
            data_done_q      <= data_done_d;
            data_err_q       <= data_err_d;
            fetch_instr_q    <= fetch_instr_d;
            data_rdata_q     <= data_rdata_d;
            ram_address_q    <= ram_address_d;
            ram_is_reading_q <= ram_is_reading_d;
            ram_data_in_q    <= ram_data_in_d;
        end
    end

    assign fetch_done    = fetch_done_q;
    assign fetch_err     = fetch_err_q;
    assign fetch_instr   = fetch_instr_q;
    assign data_done     = data_done_q;
    assign data_err      = data_err_q;
    assign data_rdata    = data_rdata_q;
    assign ram_address   = ram_address_q;
    assign ram_isReading = ram_is_reading_q;
    assign ram_dataIn    = ram_data_in_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a big-endian byte RAM model.
module tb_ram_access_arbiter;

    logic        clk;
    logic        reset;
    logic        fetch_req;
    logic [10:0] fetch_addr;
    logic        fetch_done;
    logic [31:0] fetch_instr;
    logic        fetch_err;
    logic        data_req;
    logic        data_write;
    logic [10:0] data_addr;
    logic [63:0] data_wdata;
    logic        data_done;
    logic [63:0] data_rdata;
    logic        data_err;
    logic [10:0] ram_address;
    logic        ram_isReading;
    logic [63:0] ram_dataIn;
    logic [63:0] ram_dataOut;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:2047];
    bit         preloaded = 1'b0;

    ram_access_arbiter dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done),
        .fetch_instr(fetch_instr), .fetch_err(fetch_err),
        .data_req(data_req), .data_write(data_write), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_done(data_done), .data_rdata(data_rdata),
        .data_err(data_err),
        .ram_address(ram_address), .ram_isReading(ram_isReading),
        .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Combinational big-endian read; write sampled at the clock while isReading is low
    always_comb begin
        ram_dataOut = '0;
        for (int i = 0; i < 8; i++)
            ram_dataOut[63-8*i -: 8] = mem[(int'(ram_address) + i) & 2047];
    end

    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
            for (int i = 0; i < 8; i++) mem[i] <= 8'(i);
            mem[24] <= 8'h8B; mem[25] <= 8'h02; mem[26] <= 8'h00; mem[27] <= 8'h01;
            preloaded <= 1'b1;
        end else if (!ram_isReading) begin
            for (int i = 0; i < 8; i++)
                mem[(int'(ram_address) + i) & 2047] <= ram_dataIn[63-8*i -: 8];
        end
    end

    task automatic do_data(input logic wr, input logic [10:0] addr, input logic [63:0] wd,
                           output int lat, output logic [63:0] rd, output logic err,
                           output int lows, output logic [10:0] low_addr,
                           output logic [63:0] low_data, output logic done_after);
        lat = 0; lows = 0; low_addr = '0; low_data = '0; rd = '0; err = 1'b0;
        data_req = 1'b1; data_write = wr; data_addr = addr; data_wdata = wd;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (!ram_isReading) begin
                lows++; low_addr = ram_address; low_data = ram_dataIn;
            end
            if (data_done) break;
        end
        rd = data_rdata; err = data_err;
        data_req = 1'b0; data_write = 1'b0;
        @(posedge clk); #1;
        done_after = data_done;
    endtask

    task automatic do_fetch(input logic [10:0] addr, output int lat, output logic [31:0] ins,
                            output logic err, output int lows);
        lat = 0; lows = 0;
        fetch_req = 1'b1; fetch_addr = addr;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (!ram_isReading) lows++;
            if (fetch_done) break;
        end
        ins = fetch_instr; err = fetch_err;
        fetch_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (ram_isReading !== 1'b1) begin errors++; $display("FAIL reset_isReading got %b want 1", ram_isReading); end
        checks++; if (ram_address !== 11'h000) begin errors++; $display("FAIL reset_address got %h want 000", ram_address); end
        checks++; if (ram_dataIn !== 64'h0) begin errors++; $display("FAIL reset_dataIn got %h want 0", ram_dataIn); end
        checks++; if ({fetch_done, fetch_err, data_done, data_err, busy} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b want 00000", {fetch_done, fetch_err, data_done, data_err, busy}); end
        checks++; if (fetch_instr !== 32'h0 || data_rdata !== 64'h0) begin errors++; $display("FAIL reset_data got %h/%h want 0/0", fetch_instr, data_rdata); end
    endtask

    task automatic test_contention();
        int ev[4];
        int n = 0;
        int both = 0;
        logic [31:0] ins0 = '0;
        logic [63:0] rd0 = '0;
        reset = 1'b1;
        fetch_addr = 11'h018; data_addr = 11'h000; data_write = 1'b0;
        fetch_req = 1'b1; data_req = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (fetch_done && data_done) both++;
            if (fetch_done && n < 4) begin ev[n] = 0; n++; ins0 = fetch_instr; end
            else if (data_done && n < 4) begin ev[n] = 1; n++; rd0 = data_rdata; end
        end
        fetch_req = 1'b0; data_req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (n !== 4) begin errors++; $display("FAIL contention_count got %0d want 4", n); end
        checks++; if (both !== 0) begin errors++; $display("FAIL contention_same_cycle got %0d want 0", both); end
        if (n == 4) begin
            checks++; if ({ev[0][0], ev[1][0], ev[2][0], ev[3][0]} !== 4'b0101) begin errors++; $display("FAIL contention_order got %b want 0101", {ev[0][0], ev[1][0], ev[2][0], ev[3][0]}); end
        end
        checks++; if (ins0 !== 32'h8B020001) begin errors++; $display("FAIL contention_fetch got %h want 8b020001", ins0); end
        checks++; if (rd0 !== 64'h0001020304050607) begin errors++; $display("FAIL contention_load got %h want 0001020304050607", rd0); end
    endtask

    task automatic test_load();
        int lat, lows; logic [63:0] rd, ld; logic err, da; logic [10:0] la;
        do_data(1'b0, 11'h000, 64'h0, lat, rd, err, lows, la, ld, da);
        checks++; if (lat !== 2) begin errors++; $display("FAIL load_latency got %0d want 2", lat); end
        checks++; if (rd !== 64'h0001020304050607) begin errors++; $display("FAIL load_data got %h want 0001020304050607", rd); end
        checks++; if (err !== 1'b0 || lows !== 0) begin errors++; $display("FAIL load_err_lows got %b/%0d want 0/0", err, lows); end
        checks++; if (da !== 1'b0) begin errors++; $display("FAIL load_done_width got %b want 0", da); end
    endtask

    task automatic test_store_load();
        int lat, lows; logic [63:0] rd, ld; logic err, da; logic [10:0] la;
        do_data(1'b1, 11'h010, 64'hDEADBEEFCAFEF00D, lat, rd, err, lows, la, ld, da);
        checks++; if (lat !== 4) begin errors++; $display("FAIL store_latency got %0d want 4", lat); end
        checks++; if (lows !== 1) begin errors++; $display("FAIL store_low_cycles got %0d want 1", lows); end
        checks++; if (la !== 11'h010 || ld !== 64'hDEADBEEFCAFEF00D) begin errors++; $display("FAIL store_bus got %h/%h want 010/deadbeefcafef00d", la, ld); end
        checks++; if ({mem[16], mem[17], mem[18], mem[19], mem[20], mem[21], mem[22], mem[23]} !== 64'hDEADBEEFCAFEF00D) begin errors++; $display("FAIL store_mem got %h want deadbeefcafef00d", {mem[16], mem[17], mem[18], mem[19], mem[20], mem[21], mem[22], mem[23]}); end
        checks++; if (mem[15] !== 8'h00 || mem[24] !== 8'h8B) begin errors++; $display("FAIL store_neighbours got %h/%h want 00/8b", mem[15], mem[24]); end
        do_data(1'b0, 11'h010, 64'h0, lat, rd, err, lows, la, ld, da);
        checks++; if (rd !== 64'hDEADBEEFCAFEF00D || lat !== 2) begin errors++; $display("FAIL store_readback got %h lat %0d want deadbeefcafef00d lat 2", rd, lat); end
    endtask

    task automatic test_fetch();
        int lat, lows; logic [31:0] ins; logic err;
        do_fetch(11'h018, lat, ins, err, lows);
        checks++; if (lat !== 2) begin errors++; $display("FAIL fetch_latency got %0d want 2", lat); end
        checks++; if (ins !== 32'h8B020001 || err !== 1'b0) begin errors++; $display("FAIL fetch_instr got %h err %b want 8b020001 err 0", ins, err); end
    endtask

    task automatic test_misaligned();
        int lat, lows; logic [63:0] rd, ld; logic err, da; logic [10:0] la; logic [31:0] ins;
        do_data(1'b1, 11'h00C, 64'h1122334455667788, lat, rd, err, lows, la, ld, da);
        checks++; if (lat !== 1 || err !== 1'b1) begin errors++; $display("FAIL misaligned_data got lat %0d err %b want lat 1 err 1", lat, err); end
        checks++; if (lows !== 0 || mem[12] !== 8'h00) begin errors++; $display("FAIL misaligned_no_write got lows %0d mem %h want 0/00", lows, mem[12]); end
        checks++; if (ram_address !== 11'h018) begin errors++; $display("FAIL misaligned_address got %h want 018", ram_address); end
        do_fetch(11'h002, lat, ins, err, lows);
        checks++; if (lat !== 1 || err !== 1'b1 || lows !== 0) begin errors++; $display("FAIL misaligned_fetch got lat %0d err %b lows %0d want 1/1/0", lat, err, lows); end
    endtask

    task automatic test_reset_mid_write();
        int lat, lows, n; logic [63:0] rd, ld; logic err, da; logic [10:0] la;
        n = 0;
        data_req = 1'b1; data_write = 1'b1; data_addr = 11'h040; data_wdata = 64'hA5A5A5A5A5A5A5A5;
        while (ram_isReading && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (ram_isReading !== 1'b0) begin errors++; $display("FAIL midwrite_reach_pulse got %b want 0", ram_isReading); end
        #2 reset = 1'b1;
        #1;
        checks++; if (ram_isReading !== 1'b1 || busy !== 1'b0 || data_done !== 1'b0) begin errors++; $display("FAIL midwrite_reset got rd %b busy %b done %b want 1/0/0", ram_isReading, busy, data_done); end
        data_req = 1'b0; data_write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        do_data(1'b0, 11'h000, 64'h0, lat, rd, err, lows, la, ld, da);
        checks++; if (lat !== 2 || rd !== 64'h0001020304050607) begin errors++; $display("FAIL midwrite_recover got lat %0d data %h want 2/0001020304050607", lat, rd); end
    endtask

    initial begin
        reset = 1'b1;
        fetch_req = 1'b0; fetch_addr = '0;
        data_req = 1'b0; data_write = 1'b0; data_addr = '0; data_wdata = '0;
        test_reset();
        test_contention();
        test_load();
        test_store_load();
        test_fetch();
        test_misaligned();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
